// File: rtl/button_draw.sv
// -----------------------------------------------------------------------------
// button_draw
//
// Purpose:
//   Streaming VGA overlay stage that draws one rectangular button from an
//   external image ROM. The incoming pixel position is turned into a ROM
//   address, the ROM's registered pixel is composited over the background, and
//   every timing signal is delayed so the output stays pixel-aligned (3 clocks
//   from input to output). A press pulse starts a "pressed" flash: the button
//   is drawn with inverted colours for PRESS_FRAMES frames.
//
// Ports:
//   clk, rst_n                 pixel clock, asynchronous active-low reset
//   hcount_in, vcount_in       current pixel position (11 bits each)
//   hsync_in, vsync_in         VGA sync inputs
//   hblnk_in, vblnk_in         VGA blanking inputs
//   rgb_in                     background pixel (12-bit RGB)
//   press                      single-cycle press pulse
//   rom_addr                   address to the button image ROM
//   rom_rgb                    ROM pixel, valid one clock after rom_addr
//   hcount_out, vcount_out     position delayed by 3 clocks
//   hsync_out, vsync_out       sync delayed by 3 clocks
//   hblnk_out, vblnk_out       blanking delayed by 3 clocks
//   rgb_out                    composited pixel
//   busy                       high while the pressed flash is active
// -----------------------------------------------------------------------------
module button_draw #(
    parameter int XPOS             = 0,
    parameter int YPOS             = 0,
    parameter int WIDTH            = 128,
    parameter int HEIGHT           = 64,
    parameter int ROM_ADDRESS_SIZE = 16,
    parameter int PRESS_FRAMES     = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [10:0]                 hcount_in,
    input  logic [10:0]                 vcount_in,
    input  logic                        hsync_in,
    input  logic                        vsync_in,
    input  logic                        hblnk_in,
    input  logic                        vblnk_in,
    input  logic [11:0]                 rgb_in,
    input  logic                        press,
    output logic [ROM_ADDRESS_SIZE-1:0] rom_addr,
    input  logic [11:0]                 rom_rgb,
    output logic [10:0]                 hcount_out,
    output logic [10:0]                 vcount_out,
    output logic                        hsync_out,
    output logic                        vsync_out,
    output logic                        hblnk_out,
    output logic                        vblnk_out,
    output logic [11:0]                 rgb_out,
    output logic                        busy
);

    // Window bounds are held in 12 bits so a window touching the right or
    // bottom screen edge cannot wrap around.
    localparam logic [11:0] X_LO       = 12'(XPOS);
    localparam logic [11:0] X_HI       = 12'(XPOS + WIDTH - 1);
    localparam logic [11:0] Y_LO       = 12'(YPOS);
    localparam logic [11:0] Y_HI       = 12'(YPOS + HEIGHT - 1);
    localparam logic [7:0]  PRESS_LOAD = 8'(PRESS_FRAMES);

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_t;

    typedef enum logic {
        IDLE,
        PRESSED
    } state_t;

    typedef enum logic {
        MODE_NORMAL,
        MODE_INVERT
    } mode_t;

    // Pipeline registers
    vga_t                        vga_d;
    vga_t                        s1_q;
    vga_t                        s2_q;
    vga_t                        out_q;
    vga_t                        out_d;
    logic                        hit_d;
    logic                        hit_s1_q;
    logic                        hit_s2_q;
    logic [7:0]                  relx;
    logic [7:0]                  rely;
    logic [ROM_ADDRESS_SIZE-1:0] rom_addr_d;
    logic [ROM_ADDRESS_SIZE-1:0] rom_addr_q;

    // Flash state
    state_t                      state_q;
    state_t                      state_d;
    logic [7:0]                  cnt_q;
    logic [7:0]                  cnt_d;
    mode_t                       mode_q;
    mode_t                       mode_d;
    logic                        vsync_edge;

    // -------------------------------------------------------------------------
    // Stage 0: window hit test and ROM address. The offsets are only ever
    // used modulo 256, so the low byte subtraction is all that is needed.
    // -------------------------------------------------------------------------
    always_comb begin
        vga_d = '{hcount: hcount_in, vcount: vcount_in,
                  hsync:  hsync_in,  vsync:  vsync_in,
                  hblnk:  hblnk_in,  vblnk:  vblnk_in,
                  rgb:    rgb_in};
        hit_d = ({1'b0, hcount_in} >= X_LO) && ({1'b0, hcount_in} <= X_HI) &&
                ({1'b0, vcount_in} >= Y_LO) && ({1'b0, vcount_in} <= Y_HI) &&
                !hblnk_in && !vblnk_in;
        relx  = hcount_in[7:0] - X_LO[7:0];
        rely  = vcount_in[7:0] - Y_LO[7:0];
        rom_addr_d = hit_d ? ROM_ADDRESS_SIZE'({rely, relx}) : '0;
    end

    // -------------------------------------------------------------------------
    // Stages 1 and 2: carry the timing, background pixel and hit flag along
    // while the ROM turns the stage-1 address into rom_rgb.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= '0;
            s2_q       <= '0;
            hit_s1_q   <= 1'b0;
            hit_s2_q   <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            s1_q       <= vga_d;
            s2_q       <= s1_q;
            hit_s1_q   <= hit_d;
            hit_s2_q   <= hit_s1_q;
            rom_addr_q <= rom_addr_d;
        end
    end

    assign rom_addr = rom_addr_q;

    // -------------------------------------------------------------------------
    // Stage 3 compositing: blanking always forces black, the button covers
    // the background inside the window, inverted while the flash is shown.
    // -------------------------------------------------------------------------
    always_comb begin
        out_d = s2_q;
        if (s2_q.hblnk || s2_q.vblnk) begin
            out_d.rgb = 12'h000;
        end else if (hit_s2_q) begin
            out_d.rgb = (mode_q == MODE_INVERT) ? (rom_rgb ^ 12'hFFF) : rom_rgb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign hcount_out = out_q.hcount;
    assign vcount_out = out_q.vcount;
    assign hsync_out  = out_q.hsync;
    assign vsync_out  = out_q.vsync;
    assign hblnk_out  = out_q.hblnk;
    assign vblnk_out  = out_q.vblnk;
    assign rgb_out    = out_q.rgb;

    // The stage-1 vsync register is exactly the previous vsync_in sample, so
    // it doubles as the edge-detect history.
    assign vsync_edge = vsync_in && !s1_q.vsync;

    // -------------------------------------------------------------------------
    // Flash FSM state register.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            mode_q  <= MODE_NORMAL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    // -------------------------------------------------------------------------
    // Flash FSM next state. The display mode only follows the FSM at a frame
    // edge so a frame is never half normal, half inverted. A press always
    // reloads the frame count, even when it lands on a vsync edge.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        if (vsync_edge) begin
            mode_d = (state_q == PRESSED) ? MODE_INVERT : MODE_NORMAL;
        end
        case (state_q)
            IDLE: begin
                if (press) begin
                    state_d = PRESSED;
                    cnt_d   = PRESS_LOAD;
                end
            end
            PRESSED: begin
                if (press) begin
                    cnt_d = PRESS_LOAD;
                end else if (vsync_edge) begin
                    if (cnt_q == 8'd1) begin
                        state_d = IDLE;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Flash FSM outputs.
    // -------------------------------------------------------------------------
    always_comb begin
        busy = (state_q == PRESSED);
    end

endmodule

// File: tb/tb_button_draw.sv
// -----------------------------------------------------------------------------
// tb_button_draw
//
// Purpose:
//   Self-checking bench for button_draw. A small registered ROM model feeds
//   the DUT, a frame-level reference model predicts addresses, busy and the
//   3-clock-delayed outputs, and each test task adds directed checks.
// -----------------------------------------------------------------------------
module tb_button_draw;

    localparam int XP = 100;
    localparam int YP = 50;
    localparam int W  = 128;
    localparam int H  = 64;
    localparam int PF = 3;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount_in;
    logic [10:0] vcount_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        hblnk_in;
    logic        vblnk_in;
    logic [11:0] rgb_in;
    logic        press;
    logic [15:0] rom_addr;
    logic [11:0] rom_rgb;
    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        hblnk_out;
    logic        vblnk_out;
    logic [11:0] rgb_out;
    logic        busy;

    int   checks   = 0;
    int   failures = 0;
    int   flashLeft;
    bit   modeInv;
    bit   prevVs;
    pix_t expQ[$];

    button_draw #(
        .XPOS(XP), .YPOS(YP), .WIDTH(W), .HEIGHT(H),
        .ROM_ADDRESS_SIZE(16), .PRESS_FRAMES(PF)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .press(press),
        .rom_addr(rom_addr), .rom_rgb(rom_rgb),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Image content: one known pixel for the directed checks, a scrambled
    // pattern everywhere else.
    function automatic logic [11:0] romFunc(input logic [15:0] a);
        if (a == 16'h0305) return 12'h0F0;
        return a[11:0] ^ {a[15:12], 8'h5A};
    endfunction

    // Registered ROM: data one clock after the address.
    always @(posedge clk) rom_rgb <= romFunc(rom_addr);

    task automatic model_reset();
        pix_t z;
        z         = '0;
        flashLeft = 0;
        modeInv   = 1'b0;
        prevVs    = 1'b0;
        expQ.delete();
        expQ.push_back(z);
        expQ.push_back(z);
    endtask

    // Drive one pixel for one clock, advance the reference model and score
    // the address, busy flag and the pixel now leaving the pipeline.
    task automatic step(input int h, input int v, input bit hs, input bit vs,
                        input bit hb, input bit vb, input logic [11:0] rgb,
                        input bit pr);
        bit          inWin;
        bit          edgeSeen;
        logic [15:0] addr;
        logic [11:0] romPix;
        pix_t        e;
        pix_t        got;
        hcount_in = h[10:0];
        vcount_in = v[10:0];
        hsync_in  = hs;
        vsync_in  = vs;
        hblnk_in  = hb;
        vblnk_in  = vb;
        rgb_in    = rgb;
        press     = pr;
        @(posedge clk);
        #1;
        edgeSeen = vs && !prevVs;
        prevVs   = vs;
        if (edgeSeen) modeInv = (flashLeft > 0);
        if (pr) flashLeft = PF;
        else if (edgeSeen && flashLeft > 0) flashLeft = flashLeft - 1;
        inWin = (h >= XP) && (h <= XP + W - 1) && (v >= YP) && (v <= YP + H - 1) && !hb && !vb;
        addr  = inWin ? {8'((v - YP) & 255), 8'((h - XP) & 255)} : 16'h0000;
        romPix = romFunc(addr);
        e.h  = h[10:0];
        e.v  = v[10:0];
        e.hs = hs;
        e.vs = vs;
        e.hb = hb;
        e.vb = vb;
        if (hb || vb)  e.rgb = 12'h000;
        else if (inWin) e.rgb = modeInv ? (romPix ^ 12'hFFF) : romPix;
        else           e.rgb = rgb;
        expQ.push_back(e);
        checks++;
        if (rom_addr !== addr) begin
            failures++;
            $display("[TB] FAIL rom_addr: got %h expected %h (h=%0d v=%0d)", rom_addr, addr, h, v);
        end
        checks++;
        if (busy !== (flashLeft > 0)) begin
            failures++;
            $display("[TB] FAIL busy: got %b expected %b", busy, flashLeft > 0);
        end
        if (expQ.size() >= 3) begin
            e   = expQ.pop_front();
            got = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
            checks++;
            if (got.rgb !== e.rgb) begin
                failures++;
                $display("[TB] FAIL rgb_out: got %h expected %h (hcount_out=%0d)", got.rgb, e.rgb, got.h);
            end
            checks++;
            if (got[37:12] !== e[37:12]) begin
                failures++;
                $display("[TB] FAIL timing_out: got %h expected %h", got[37:12], e[37:12]);
            end
        end
    endtask

    task automatic rand_pixel(input bit pr);
        int h;
        int v;
        if ($urandom_range(0, 3) == 0) begin
            h = $urandom_range(0, 2047);
            v = $urandom_range(0, 2047);
        end else begin
            h = XP - 2 + $urandom_range(0, W + 3);
            v = YP - 2 + $urandom_range(0, H + 3);
        end
        step(h, v, $urandom_range(0, 7) == 0, 1'b0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 15) == 0, 12'($urandom), pr);
    endtask

    // A compressed frame: vertical blanking with a vsync pulse, then random
    // active pixels. pressAt < 0 means no press among the active pixels.
    task automatic run_frame(input int nPix, input int pressAt, input bit pressOnEdge);
        for (int i = 0; i < 2; i++) step(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 12'($urandom), 1'b0);
        for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 12'($urandom), pressOnEdge && (i == 0));
        for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 12'($urandom), 1'b0);
        for (int i = 0; i < nPix; i++) rand_pixel(i == pressAt);
    endtask

    // Push the known button pixel (105,53) through and return what leaves
    // the pipeline for it.
    task automatic probe(output logic [11:0] gotRgb, output logic [10:0] gotH);
        step(105, 53, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 1'b0);
        step(5, 5, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456, 1'b0);
        step(6, 5, 1'b0, 1'b0, 1'b0, 1'b0, 12'h789, 1'b0);
        gotRgb = rgb_out;
        gotH   = hcount_out;
    endtask

    task automatic test_reset();
        logic [11:0] r;
        logic [10:0] hh;
        logic [38:0] allOut;
        rst_n = 1'b0;
        hcount_in = '0; vcount_in = '0; hsync_in = 0; vsync_in = 0;
        hblnk_in = 0; vblnk_in = 0; rgb_in = '0; press = 0;
        repeat (3) @(posedge clk);
        #1;
        allOut = {rom_addr[10:0], hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out, busy};
        checks++;
        if (allOut !== '0 || rom_addr !== 16'h0) begin
            failures++;
            $display("[TB] FAIL reset_state: got %h/%h expected 0", allOut, rom_addr);
        end
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        run_frame(20, 5, 1'b0);
        for (int i = 0; i < 10; i++) rand_pixel(1'b0);
        #2 rst_n = 1'b0;
        #1;
        allOut = {rom_addr[10:0], hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out, busy};
        checks++;
        if (allOut !== '0 || rom_addr !== 16'h0) begin
            failures++;
            $display("[TB] FAIL midstream_reset: got %h/%h expected 0", allOut, rom_addr);
        end
        press = 0;
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        run_frame(10, -1, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stale_flash_busy: got %b expected 0", busy);
        end
        probe(r, hh);
        checks++;
        if (r !== 12'h0F0) begin
            failures++;
            $display("[TB] FAIL stale_flash_rgb: got %h expected 0f0", r);
        end
    endtask

    task automatic test_address_map();
        logic [11:0] r;
        step(105, 53, 1'b0, 1'b0, 1'b0, 1'b0, 12'h111, 1'b0);
        checks++;
        if (rom_addr !== 16'h0305) begin
            failures++;
            $display("[TB] FAIL addr_105_53: got %h expected 0305", rom_addr);
        end
        step(99, 53, 1'b0, 1'b0, 1'b0, 1'b0, 12'h3C7, 1'b0);
        checks++;
        if (rom_addr !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL addr_99_53: got %h expected 0000", rom_addr);
        end
        step(5, 5, 1'b0, 1'b0, 1'b0, 1'b0, 12'h222, 1'b0);
        step(6, 5, 1'b0, 1'b0, 1'b0, 1'b0, 12'h333, 1'b0);
        r = rgb_out;
        checks++;
        if (r !== 12'h3C7 || hcount_out !== 11'd99) begin
            failures++;
            $display("[TB] FAIL bypass_99: got rgb %h h %0d expected rgb 3c7 h 99", r, hcount_out);
        end
    endtask

    task automatic test_compositing();
        logic [11:0] r;
        logic [10:0] hh;
        probe(r, hh);
        checks++;
        if (r !== 12'h0F0 || hh !== 11'd105) begin
            failures++;
            $display("[TB] FAIL composite_105: got rgb %h h %0d expected rgb 0f0 h 105", r, hh);
        end
        step(105, 53, 1'b0, 1'b0, 1'b1, 1'b0, 12'hABC, 1'b0);
        step(5, 5, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456, 1'b0);
        step(6, 5, 1'b0, 1'b0, 1'b0, 1'b0, 12'h789, 1'b0);
        checks++;
        if (rgb_out !== 12'h000 || hcount_out !== 11'd105) begin
            failures++;
            $display("[TB] FAIL composite_blank: got rgb %h h %0d expected rgb 000 h 105", rgb_out, hcount_out);
        end
        for (int f = 0; f < 3; f++) run_frame(60, -1, 1'b0);
    endtask

    task automatic test_flash();
        logic [11:0] r;
        logic [10:0] hh;
        run_frame(10, -1, 1'b0);
        step(3, 3, 1'b0, 1'b0, 1'b0, 1'b0, 12'h010, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL flash_busy_rise: got %b expected 1", busy);
        end
        probe(r, hh);
        checks++;
        if (r !== 12'h0F0) begin
            failures++;
            $display("[TB] FAIL flash_frame0: got %h expected 0f0", r);
        end
        for (int f = 1; f <= 4; f++) begin
            run_frame(15, -1, 1'b0);
            checks++;
            if (busy !== (f < 3)) begin
                failures++;
                $display("[TB] FAIL flash_busy_f%0d: got %b expected %b", f, busy, f < 3);
            end
            probe(r, hh);
            checks++;
            if (r !== ((f <= 3) ? 12'hF0F : 12'h0F0)) begin
                failures++;
                $display("[TB] FAIL flash_rgb_f%0d: got %h expected %h", f, r, (f <= 3) ? 12'hF0F : 12'h0F0);
            end
        end
    endtask

    task automatic test_retrigger();
        logic [11:0] r;
        logic [10:0] hh;
        run_frame(10, 4, 1'b0);
        for (int f = 1; f <= 6; f++) begin
            run_frame(15, (f == 2) ? 7 : -1, 1'b0);
            checks++;
            if (busy !== (f < 5)) begin
                failures++;
                $display("[TB] FAIL retrig_busy_f%0d: got %b expected %b", f, busy, f < 5);
            end
            probe(r, hh);
            checks++;
            if (r !== ((f <= 5) ? 12'hF0F : 12'h0F0)) begin
                failures++;
                $display("[TB] FAIL retrig_rgb_f%0d: got %h expected %h", f, r, (f <= 5) ? 12'hF0F : 12'h0F0);
            end
        end
        // Press landing on a vsync edge while already flashing.
        run_frame(10, 3, 1'b0);
        run_frame(10, -1, 1'b0);
        run_frame(10, -1, 1'b1);
        for (int f = 1; f <= 3; f++) begin
            run_frame(10, -1, 1'b0);
            checks++;
            if (busy !== (f < 3)) begin
                failures++;
                $display("[TB] FAIL edge_press_busy_f%0d: got %b expected %b", f, busy, f < 3);
            end
        end
    endtask

    task automatic test_window_edges();
        step(XP + 127, YP + 10, 1'b0, 1'b0, 1'b0, 1'b0, 12'h111, 1'b0);
        checks++;
        if (rom_addr !== 16'h0A7F) begin
            failures++;
            $display("[TB] FAIL right_edge_in: got %h expected 0a7f", rom_addr);
        end
        step(XP + 128, YP + 10, 1'b0, 1'b0, 1'b0, 1'b0, 12'h222, 1'b0);
        checks++;
        if (rom_addr !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL right_edge_out: got %h expected 0000", rom_addr);
        end
        step(XP + 5, YP + 63, 1'b0, 1'b0, 1'b0, 1'b0, 12'h333, 1'b0);
        checks++;
        if (rom_addr !== 16'h3F05) begin
            failures++;
            $display("[TB] FAIL bottom_edge_in: got %h expected 3f05", rom_addr);
        end
        step(XP + 5, YP + 64, 1'b0, 1'b0, 1'b0, 1'b0, 12'h444, 1'b0);
        checks++;
        if (rom_addr !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL bottom_edge_out: got %h expected 0000", rom_addr);
        end
        step(XP, YP - 1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h555, 1'b0);
        step(XP - 1, YP, 1'b0, 1'b0, 1'b0, 1'b0, 12'h666, 1'b0);
        step(XP + 1, YP + 1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h777, 1'b0);
        checks++;
        if (rom_addr !== 16'h0101) begin
            failures++;
            $display("[TB] FAIL top_left_in: got %h expected 0101", rom_addr);
        end
        run_frame(40, -1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_address_map();
        test_compositing();
        test_flash();
        test_retrigger();
        test_window_edges();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
